// File: rtl/memory_arbiter_pkg.sv
// Shared types for the main-memory arbiter: FSM state, requesting port and
// operation encodings, plus default bus widths.
package memory_arbiter_pkg;

  localparam int unsigned DEF_ADDR_SIZE  = 32;
  localparam int unsigned DEF_LINE_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/memory_arbiter_mem_array.sv
// Single-port synchronous line-wide RAM with a registered, resettable read port.
// The array itself is never reset so it can map onto block RAM.
module memory_arbiter_mem_array #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned IDX_BITS   = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [IDX_BITS-1:0]   idx_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  output logic [LINE_WIDTH-1:0] rdata_o
);

  logic [LINE_WIDTH-1:0] mem_q [0:(2**IDX_BITS)-1];
  logic [LINE_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_arbiter.sv
// Main-memory stage behind the I/D caches: round-robin arbitration, one request
// in flight, fixed-latency fill or writeback-completion pulse.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_SIZE        = DEF_ADDR_SIZE,
  parameter int unsigned LINE_WIDTH       = DEF_LINE_WIDTH,
  parameter int unsigned LINE_OFFSET_BITS = 4,
  parameter int unsigned MEM_LINES        = 4096,
  parameter int unsigned LATENCY          = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_miss,
  input  logic [ADDR_SIZE-1:0]  i_address,
  output logic                  i_fill_valid,
  input  logic                  d_miss,
  input  logic                  d_write,
  input  logic [ADDR_SIZE-1:0]  d_address,
  input  logic [LINE_WIDTH-1:0] d_write_data,
  output logic                  d_fill_valid,
  output logic                  d_write_done,
  output logic [LINE_WIDTH-1:0] fill_data,
  output logic                  busy
);

  localparam int unsigned IDX_BITS = $clog2(MEM_LINES);
  localparam int unsigned IDX_HI   = LINE_OFFSET_BITS + IDX_BITS - 1;
  localparam int unsigned CNT_BITS = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_e                state_q;
  port_e                 last_grant_q, port_q;
  op_e                   op_q;
  logic [IDX_BITS-1:0]   idx_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic                  i_fill_q, d_fill_q, d_done_q;

  logic                  i_req_d, d_req_d, grant_valid_d;
  port_e                 grant_port_d;
  op_e                   grant_op_d;
  logic [IDX_BITS-1:0]   grant_idx_d;

  logic                  enter_resp_d, ram_we_d, ram_re_d;
  port_e                 ram_port_d;
  op_e                   ram_op_d;
  logic [IDX_BITS-1:0]   ram_idx_d;
  logic [LINE_WIDTH-1:0] ram_wdata_d;

  // Bits above and below the line index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_address, d_address};

  always_comb begin
    i_req_d       = i_miss;
    d_req_d       = d_miss | d_write;
    grant_valid_d = i_req_d | d_req_d;
    grant_port_d  = PORT_INSTR;
    if (i_req_d && d_req_d)
      grant_port_d = (last_grant_q == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
    else if (d_req_d)
      grant_port_d = PORT_DATA;
    grant_op_d  = (grant_port_d == PORT_DATA && d_write) ? OP_WRITE : OP_READ;
    grant_idx_d = (grant_port_d == PORT_DATA) ? d_address[IDX_HI:LINE_OFFSET_BITS]
                                              : i_address[IDX_HI:LINE_OFFSET_BITS];
  end

  // With LATENCY==1 the accept edge is also the RESPOND entry edge, so the RAM
  // must see the live grant rather than the not-yet-captured registers.
  always_comb begin
    enter_resp_d = ((state_q == ST_IDLE) && grant_valid_d && (LATENCY == 1)) ||
                   ((state_q == ST_BUSY) && (cnt_q == '0));
    ram_port_d   = (state_q == ST_IDLE) ? grant_port_d : port_q;
    ram_op_d     = (state_q == ST_IDLE) ? grant_op_d   : op_q;
    ram_idx_d    = (state_q == ST_IDLE) ? grant_idx_d  : idx_q;
    ram_wdata_d  = (state_q == ST_IDLE) ? d_write_data : wdata_q;
    ram_we_d     = enter_resp_d && (ram_op_d == OP_WRITE) && reset_n;
    ram_re_d     = enter_resp_d && (ram_op_d == OP_READ);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_DATA;
      port_q       <= PORT_INSTR;
      op_q         <= OP_READ;
      idx_q        <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      i_fill_q     <= 1'b0;
      d_fill_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      i_fill_q <= 1'b0;
      d_fill_q <= 1'b0;
      d_done_q <= 1'b0;
      if (enter_resp_d) begin
        i_fill_q <= (ram_port_d == PORT_INSTR);
        d_fill_q <= (ram_port_d == PORT_DATA) && (ram_op_d == OP_READ);
        d_done_q <= (ram_op_d == OP_WRITE);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (grant_valid_d) begin
            port_q  <= grant_port_d;
            op_q    <= grant_op_d;
            idx_q   <= grant_idx_d;
            wdata_q <= d_write_data;
            if (i_req_d && d_req_d) last_grant_q <= grant_port_d;
            if (LATENCY == 1) begin
              state_q <= ST_RESPOND;
            end else begin
              state_q <= ST_BUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) state_q <= ST_RESPOND;
          else             cnt_q   <= cnt_q - CNT_BITS'(1);
        end
        ST_RESPOND: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  memory_arbiter_mem_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .IDX_BITS   (IDX_BITS)
  ) u_mem (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .we_i    (ram_we_d),
    .re_i    (ram_re_d),
    .idx_i   (ram_idx_d),
    .wdata_i (ram_wdata_d),
    .rdata_o (fill_data)
  );

  assign i_fill_valid = i_fill_q;
  assign d_fill_valid = d_fill_q;
  assign d_write_done = d_done_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench: default-parameter arbiter (A) and a LATENCY=1, 16-line
// arbiter (B) sharing clock, reset and request inputs.
module tb_memory_arbiter;

  localparam logic [127:0] DB = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] L1 = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] L2 = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] L5 = 128'h55555555_55555555_55555555_55555555;

  logic         clock, reset_n;
  logic         i_miss, d_miss, d_write;
  logic [31:0]  i_address, d_address;
  logic [127:0] d_write_data;

  logic         a_i_fill, a_d_fill, a_d_done, a_busy;
  logic [127:0] a_fill;
  logic         b_i_fill, b_d_fill, b_d_done, b_busy;
  logic [127:0] b_fill;

  int n_checks = 0;
  int n_errors = 0;

  memory_arbiter u_dut_a (
    .clock(clock), .reset_n(reset_n),
    .i_miss(i_miss), .i_address(i_address), .i_fill_valid(a_i_fill),
    .d_miss(d_miss), .d_write(d_write), .d_address(d_address),
    .d_write_data(d_write_data), .d_fill_valid(a_d_fill),
    .d_write_done(a_d_done), .fill_data(a_fill), .busy(a_busy)
  );

  memory_arbiter #(.MEM_LINES(16), .LATENCY(1)) u_dut_b (
    .clock(clock), .reset_n(reset_n),
    .i_miss(i_miss), .i_address(i_address), .i_fill_valid(b_i_fill),
    .d_miss(d_miss), .d_write(d_write), .d_address(d_address),
    .d_write_data(d_write_data), .d_fill_valid(b_d_fill),
    .d_write_done(b_d_done), .fill_data(b_fill), .busy(b_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drop_all();
    i_miss  = 1'b0;
    d_miss  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (!a_busy && !b_busy) break;
    end
    check("idle_reached", {a_busy, b_busy}, 2'b00);
  endtask

  // Returns edge count (accept edge = 1) of the first response pulse; leaves
  // the caller just after the RESPOND closing edge.
  task automatic wait_pulse(input int inst, output int lat, output logic [2:0] pul,
                            output logic [127:0] fd);
    lat = -1;
    pul = '0;
    fd  = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      pul = (inst == 0) ? {a_i_fill, a_d_fill, a_d_done} : {b_i_fill, b_d_fill, b_d_done};
      if (pul != 3'b000) begin
        lat = k;
        fd  = (inst == 0) ? a_fill : b_fill;
        check("busy_in_respond", (inst == 0) ? a_busy : b_busy, 1'b1);
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clock);
      #1;
      check("pulse_width", (inst == 0) ? {a_i_fill, a_d_fill, a_d_done}
                                        : {b_i_fill, b_d_fill, b_d_done}, 3'b000);
    end
  endtask

  task automatic single(input string name, input int inst, input logic is_i, input logic wr,
                        input logic [31:0] addr, input logic [127:0] wd, input int exp_lat,
                        input logic [2:0] exp_pul, input logic chk_fd,
                        input logic [127:0] exp_fd);
    int           lat;
    logic [2:0]   pul;
    logic [127:0] fd;
    wait_idle();
    if (is_i) begin
      i_miss    = 1'b1;
      i_address = addr;
    end else begin
      d_write      = wr;
      d_miss       = !wr;
      d_address    = addr;
      d_write_data = wd;
    end
    wait_pulse(inst, lat, pul, fd);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_pulse"}, pul, exp_pul);
    if (chk_fd) check({name, "_data"}, fd, exp_fd);
    if (inst == 1) check({name, "_busy_after"}, b_busy, 1'b0);
    drop_all();
  endtask

  task automatic tie(input string name, input logic [2:0] first_pul, input logic [127:0] first_fd,
                     input logic [2:0] second_pul, input logic [127:0] second_fd);
    int           lat;
    logic [2:0]   pul;
    logic [127:0] fd;
    wait_idle();
    i_miss    = 1'b1;
    i_address = 32'h0000_0100;
    d_miss    = 1'b1;
    d_address = 32'h0000_0200;
    wait_pulse(0, lat, pul, fd);
    check({name, "_first_lat"}, lat, 5);
    check({name, "_first_grant"}, pul, first_pul);
    check({name, "_first_data"}, fd, first_fd);
    if (first_pul[2]) i_miss = 1'b0;
    else              d_miss = 1'b0;
    wait_pulse(0, lat, pul, fd);
    check({name, "_second_lat"}, lat, 5);
    check({name, "_second_grant"}, pul, second_pul);
    check({name, "_second_data"}, fd, second_fd);
    drop_all();
  endtask

  initial begin
    logic saw_done;
    reset_n      = 1'b0;
    i_miss       = 1'b0;
    d_miss       = 1'b0;
    d_write      = 1'b0;
    i_address    = '0;
    d_address    = '0;
    d_write_data = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      check("reset_idle_ctl", {a_i_fill, a_d_fill, a_d_done, a_busy,
                               b_i_fill, b_d_fill, b_d_done, b_busy}, 8'h00);
      check("reset_idle_fill", a_fill | b_fill, 128'h0);
    end

    single("wb_40", 0, 1'b0, 1'b1, 32'h0000_0040, DB, 5, 3'b001, 1'b0, '0);
    single("fill_40", 0, 1'b0, 1'b0, 32'h0000_0040, '0, 5, 3'b010, 1'b1, DB);
    single("wb_100", 0, 1'b0, 1'b1, 32'h0000_0100, L1, 5, 3'b001, 1'b0, '0);
    single("wb_200", 0, 1'b0, 1'b1, 32'h0000_0200, L2, 5, 3'b001, 1'b0, '0);

    tie("tie1", 3'b100, L1, 3'b010, L2);
    tie("tie2", 3'b010, L2, 3'b100, L1);

    // Writeback interrupted by reset two cycles after acceptance.
    wait_idle();
    d_write      = 1'b1;
    d_address    = 32'h0000_0040;
    d_write_data = L5;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    d_write = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("midrst_fill_cleared", a_fill, 128'h0);
    check("midrst_busy", a_busy, 1'b0);
    saw_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      saw_done = saw_done | a_d_done;
    end
    check("midrst_no_done", saw_done, 1'b0);
    single("midrst_readback", 0, 1'b0, 1'b0, 32'h0000_0040, '0, 5, 3'b010, 1'b1, DB);

    single("b_wb_010", 1, 1'b0, 1'b1, 32'h0000_0010, 128'h1, 1, 3'b001, 1'b0, '0);
    single("b_alias_110", 1, 1'b0, 1'b0, 32'h0000_0110, '0, 1, 3'b010, 1'b1, 128'h1);
    single("b_instr_010", 1, 1'b1, 1'b0, 32'h0000_0010, '0, 1, 3'b100, 1'b1, 128'h1);

    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Main-memory stage directly downstream of the instruction and data caches.
- Accepts line-fill requests (cache miss) and dirty-line writebacks, arbitrates between the two caches, and services one request at a time.
- Services each request against an internal line-wide memory array with fixed latency.
- Returns a one-cycle fill pulse with line data, or a one-cycle write-completion pulse, in the exact form the caches consume.

Parameters:
- ADDR_SIZE, 32, physical address width.
- LINE_WIDTH, 128, bits per cache line and per memory word.
- LINE_OFFSET_BITS, 4, low address bits below line granularity, ignored for indexing.
- MEM_LINES, 4096, number of lines in the backing array (power of two).
- LATENCY, 5, cycles from accept edge to response pulse; minimum 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_miss  input  1  instruction cache requests a line fill (level, held until serviced).
- i_address  input  ADDR_SIZE  instruction cache request address.
- i_fill_valid  output  1  one-cycle pulse: fill_data holds the instruction line.
- d_miss  input  1  data cache requests a line fill (level).
- d_write  input  1  data cache requests a dirty writeback (level).
- d_address  input  ADDR_SIZE  data cache request address (line address for a writeback).
- d_write_data  input  LINE_WIDTH  dirty line to write back.
- d_fill_valid  output  1  one-cycle pulse: fill_data holds the data line.
- d_write_done  output  1  one-cycle pulse: writeback committed.
- fill_data  output  LINE_WIDTH  response line, shared by both ports.
- busy  output  1  high while a request is in flight (BUSY or RESPOND).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state goes to IDLE; counter cleared; last_grant set to DATA, so INSTR wins the first tie.
  - All pulses low; fill_data all zeros.
  - Memory array contents are NOT reset.
- Index: idx = address[LINE_OFFSET_BITS + log2(MEM_LINES) - 1 : LINE_OFFSET_BITS]. Higher bits are ignored, so addresses alias modulo MEM_LINES lines.
- Data-port request type: d_write has priority over d_miss if both are high (the cache never drives both).
- FSM states: IDLE, BUSY, RESPOND.
- IDLE:
  - With no request, stay in IDLE.
  - With exactly one port requesting, grant that port.
  - With both ports requesting, grant the port not in last_grant (round-robin), then update last_grant.
  - At the accept edge, register the granted port, the op (READ/WRITE), idx and d_write_data.
  - Then go to RESPOND if LATENCY == 1; otherwise go to BUSY with counter = LATENCY-2.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESPOND at the next edge.
- Entry edge into RESPOND:
  - READ: fill_data <= mem[idx].
  - WRITE: mem[idx] <= captured data.
- RESPOND: lasts exactly one cycle.
  - Exactly one of i_fill_valid, d_fill_valid or d_write_done is high, as a registered output.
  - Then return to IDLE.
- Timing: response pulse is high in the cycle that begins LATENCY edges after the accept edge.
- Handshake:
  - The caches consume the pulse at the RESPOND cycle's closing edge and drop their request level in the following cycle.
  - IDLE re-samples request levels in that following cycle, so the same request is never serviced twice.
- Request changes during BUSY are ignored; captured values are used.
- Ordering: a writeback followed by a fill of the same line (from either port) returns the written data.
- fill_data holds its last value outside RESPOND.
- busy = (state != IDLE).
- Reset mid-operation: the in-flight request is dropped with no pulse. A pending WRITE not yet at the RESPOND entry edge is not committed. Requests still held after reset are re-accepted normally.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/BUSY/RESPOND);
  - port ID enum (INSTR/DATA);
  - op enum (READ/WRITE), matching the codebase WRITE/READ constants;
  - default LINE_WIDTH / ADDR_SIZE constants.
- Sub-module mem_array: single-port synchronous line-wide RAM (write enable, index, write data, registered read data), so it can map to block RAM.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles, release with no requests -> all pulses 0, fill_data=0, busy=0 for 20 cycles.
- Writeback then fill, LATENCY=5:
  - d_write=1, d_address=0x0000_0040, d_write_data=0xDEAD...BEEF -> d_write_done pulses exactly 5 cycles after accept, one cycle wide.
  - Then d_miss on 0x40 -> d_fill_valid pulses with fill_data=0xDEAD...BEEF.
- Simultaneous requests from reset: i_miss (0x100) and d_miss (0x200) raised together -> INSTR serviced first, DATA accepted the cycle after the cache drops i_miss. Repeated ties alternate grants.
- Aliasing: MEM_LINES=16, write 0x1 to line address 0x010, read 0x110 -> fill_data=0x1.
- LATENCY=1: d_miss accepted at edge E -> d_fill_valid high in the cycle right after E, busy high for 1 cycle.
- Mid-op reset: start a write at cycle 0, pulse reset_n low at cycle 2 -> no d_write_done. A later read of the same line returns the prior contents.
